// File: rtl/bcd_to_bin_n_pkg.sv
// rtl/bcd_to_bin_n_pkg.sv - shared constants and helpers for the BCD-to-binary converter
package bcd_to_bin_n_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int BCD_DIG_W = 4;

   // Never returns less than 1 so a one-bit counter still exists for tiny widths.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((32'sd1 <<< r) < value) begin
         r = r + 1;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_to_bin_n_digit_corr.sv
// rtl/bcd_to_bin_n_digit_corr.sv - per-digit reverse double-dabble correction (d>=8 -> d-3)
module bcd_digit_corr
   import bcd_to_bin_n_pkg::*;
(
   input  logic [BCD_DIG_W-1:0] d_i,
   output logic [BCD_DIG_W-1:0] d_o
);

   assign d_o = (d_i >= 4'd8) ? (d_i - 4'd3) : d_i;

endmodule

// File: rtl/bcd_to_bin_n.sv
// rtl/bcd_to_bin_n.sv - sequential BCD-to-binary converter, one shift-and-correct per clock
module bcd_to_bin_n
   import bcd_to_bin_n_pkg::*;
#(
   parameter int NDIG  = 5,
   parameter int BIN_W = 17
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      init_i,
   input  logic [BCD_DIG_W*NDIG-1:0] bcd_i,
   output logic [BIN_W-1:0]          bin_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic                      ovf_o
);

   localparam int D_W   = NDIG * BCD_DIG_W;
   localparam int A_W   = D_W + BIN_W;
   localparam int CNT_W = clog2(BIN_W + 1);

   logic [1:0]       state_q, state_d;
   logic [D_W-1:0]   d_q, d_d;
   logic [BIN_W-1:0] b_q, b_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             ovf_q, ovf_d;

   logic [A_W-1:0]   a_shift;
   logic [D_W-1:0]   d_shift;
   logic [D_W-1:0]   d_corr;
   logic [BIN_W-1:0] b_shift;
   logic [NDIG-1:0]  digit_bad;

   assign a_shift = {d_q, b_q} >> 1;
   assign d_shift = a_shift[A_W-1:BIN_W];
   assign b_shift = a_shift[BIN_W-1:0];

   for (genvar g = 0; g < NDIG; g++) begin : g_dig
      bcd_digit_corr u_corr (
         .d_i (d_shift[g*BCD_DIG_W +: BCD_DIG_W]),
         .d_o (d_corr[g*BCD_DIG_W +: BCD_DIG_W])
      );
      assign digit_bad[g] = (bcd_i[g*BCD_DIG_W +: BCD_DIG_W] > 4'd9);
   end

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      b_d     = b_q;
      bin_d   = bin_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = err_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (init_i) begin
               if (|digit_bad) begin
                  // Bad input short-circuits straight to DONE; no shifting happens.
                  err_d   = 1'b1;
                  ovf_d   = 1'b0;
                  bin_d   = '0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  d_d     = bcd_i;
                  b_d     = '0;
                  cnt_d   = CNT_W'(BIN_W);
                  err_d   = 1'b0;
                  ovf_d   = 1'b0;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            d_d   = d_corr;
            b_d   = b_shift;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // Whatever is left in the BCD half is value / 2^BIN_W.
               bin_d   = b_shift;
               ovf_d   = (d_corr != '0);
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         d_q     <= '0;
         b_q     <= '0;
         bin_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         b_q     <= b_d;
         bin_q   <= bin_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bin_o  = bin_q;
   assign busy_o = (state_q != ST_IDLE);
   assign done_o = done_q;
   assign err_o  = err_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_bcd_to_bin_n.sv
// tb/tb_bcd_to_bin_n.sv - self-checking bench for bcd_to_bin_n (5/17 and 3/8 instances)
module tb_bcd_to_bin_n;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_a, init_b;
   logic [19:0] bcd_a;
   logic [11:0] bcd_b;
   logic [16:0] bin_a;
   logic [7:0]  bin_b;
   logic        busy_a, done_a, err_a, ovf_a;
   logic        busy_b, done_b, err_b, ovf_b;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bcd_to_bin_n #(.NDIG(5), .BIN_W(17)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .init_i(init_a), .bcd_i(bcd_a),
      .bin_o(bin_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .ovf_o(ovf_a)
   );

   bcd_to_bin_n #(.NDIG(3), .BIN_W(8)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .init_i(init_b), .bcd_i(bcd_b),
      .bin_o(bin_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .ovf_o(ovf_b)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: decimal value from digits, result = value mod 2^w, latency w+1 (or 1 for bad input).
   bit      m_valid = 1'b0;
   bit      m_busy[2], m_done[2], m_err[2], m_ovf[2], m_pbad[2];
   longint  m_bin[2], m_pval[2];
   int      m_to_done[2];

   task automatic decode(input logic [39:0] bcd, input int ndig, output bit bad, output longint val);
      logic [3:0] dig;
      bad = 1'b0;
      val = 0;
      for (int i = ndig - 1; i >= 0; i--) begin
         dig = bcd[4*i +: 4];
         if (dig > 4'd9) bad = 1'b1;
         val = val * 10 + longint'(dig);
      end
   endtask

   task automatic publish(input int k, input int w);
      longint lim;
      lim = longint'(1) <<< w;
      m_done[k] = 1'b1;
      if (m_pbad[k]) begin
         m_err[k] = 1'b1;
         m_ovf[k] = 1'b0;
         m_bin[k] = 0;
      end else begin
         m_err[k] = 1'b0;
         m_bin[k] = m_pval[k] % lim;
         m_ovf[k] = (m_pval[k] >= lim);
      end
   endtask

   task automatic model_step(input int k, input logic r, input logic ini,
                             input logic [39:0] bcd, input int ndig, input int w);
      bit     bad;
      longint val;
      if (r) begin
         m_busy[k] = 0; m_done[k] = 0; m_err[k] = 0; m_ovf[k] = 0;
         m_bin[k] = 0; m_to_done[k] = 0;
      end else if (!m_busy[k]) begin
         if (ini) begin
            decode(bcd, ndig, bad, val);
            m_pbad[k] = bad;
            m_pval[k] = val;
            m_busy[k] = 1'b1;
            m_to_done[k] = bad ? 0 : w;
            if (!bad) begin
               m_err[k] = 1'b0;
               m_ovf[k] = 1'b0;
            end
            if (m_to_done[k] == 0) publish(k, w);
         end
      end else if (m_done[k]) begin
         m_busy[k] = 1'b0;
         m_done[k] = 1'b0;
      end else begin
         m_to_done[k]--;
         if (m_to_done[k] == 0) publish(k, w);
      end
   endtask

   always @(posedge clk) begin
      model_step(0, rst, init_a, {20'd0, bcd_a}, 5, 17);
      model_step(1, rst, init_b, {28'd0, bcd_b}, 3, 8);
      if (rst) m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("a_busy", 64'(busy_a), 64'(m_busy[0]));
         chk("a_done", 64'(done_a), 64'(m_done[0]));
         chk("a_err",  64'(err_a),  64'(m_err[0]));
         chk("a_ovf",  64'(ovf_a),  64'(m_ovf[0]));
         chk("a_bin",  64'(bin_a),  64'(m_bin[0]));
         chk("b_busy", 64'(busy_b), 64'(m_busy[1]));
         chk("b_done", 64'(done_b), 64'(m_done[1]));
         chk("b_err",  64'(err_b),  64'(m_err[1]));
         chk("b_ovf",  64'(ovf_b),  64'(m_ovf[1]));
         chk("b_bin",  64'(bin_b),  64'(m_bin[1]));
      end
   end

   // Called just after a negedge; returns the cycle index (accept cycle = 0) where done is seen.
   task automatic run_a(input logic [19:0] v, output int cyc);
      init_a = 1'b1;
      bcd_a  = v;
      cyc    = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         init_a = 1'b0;
         cyc++;
         if (done_a === 1'b1) return;
      end
      n_assert++;
      n_fail++;
      $display("FAIL a_timeout: no done after %0d cycles, required within 40", cyc);
   endtask

   task automatic run_b(input logic [11:0] v, output int cyc);
      init_b = 1'b1;
      bcd_b  = v;
      cyc    = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         init_b = 1'b0;
         cyc++;
         if (done_b === 1'b1) return;
      end
      n_assert++;
      n_fail++;
      $display("FAIL b_timeout: no done after %0d cycles, required within 40", cyc);
   endtask

   initial begin
      int cyc;
      rst = 1'b1; init_a = 1'b0; init_b = 1'b0; bcd_a = '0; bcd_b = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_bin",  64'(bin_a),  64'd0);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_done", 64'(done_a), 64'd0);
      chk("rst_flags", 64'({err_a, ovf_a}), 64'd0);
      @(negedge clk);

      run_a(20'h99999, cyc);
      chk("max_lat", 64'(cyc), 64'd18);
      chk("max_bin", 64'(bin_a), 64'h1869F);
      chk("max_flags", 64'({err_a, ovf_a}), 64'd0);
      @(negedge clk);
      chk("max_idle", 64'(busy_a), 64'd0);

      run_a(20'h00000, cyc);
      chk("zero_lat", 64'(cyc), 64'd18);
      chk("zero_bin", 64'(bin_a), 64'd0);
      @(negedge clk);
      run_a(20'h00001, cyc);
      chk("one_bin", 64'(bin_a), 64'd1);
      @(negedge clk);

      run_a(20'h0A123, cyc);
      chk("bad_lat", 64'(cyc), 64'd1);
      chk("bad_err", 64'(err_a), 64'd1);
      chk("bad_bin", 64'(bin_a), 64'd0);
      chk("bad_ovf", 64'(ovf_a), 64'd0);
      @(negedge clk);
      run_a(20'h00042, cyc);
      chk("clr_err", 64'(err_a), 64'd0);
      chk("clr_bin", 64'(bin_a), 64'd42);
      @(negedge clk);

      // init re-pulses while busy must be dropped
      init_a = 1'b1; bcd_a = 20'h12345;
      @(negedge clk); init_a = 1'b0;
      repeat (4) @(negedge clk);
      init_a = 1'b1; bcd_a = 20'h00007;
      @(negedge clk); init_a = 1'b0;
      repeat (12) @(negedge clk);
      chk("ign_done", 64'(done_a), 64'd1);
      chk("ign_bin", 64'(bin_a), 64'h03039);
      init_a = 1'b1;
      @(negedge clk);
      chk("ign_nodone", 64'(done_a), 64'd0);
      run_a(20'h00007, cyc);
      chk("ign_next_lat", 64'(cyc), 64'd18);
      chk("ign_next_bin", 64'(bin_a), 64'd7);
      @(negedge clk);

      run_b(12'h255, cyc);
      chk("b255_lat", 64'(cyc), 64'd9);
      chk("b255_bin", 64'(bin_b), 64'd255);
      chk("b255_ovf", 64'(ovf_b), 64'd0);
      @(negedge clk);
      run_b(12'h256, cyc);
      chk("b256_bin", 64'(bin_b), 64'd0);
      chk("b256_ovf", 64'(ovf_b), 64'd1);
      @(negedge clk);
      run_b(12'h999, cyc);
      chk("b999_bin", 64'(bin_b), 64'hE7);
      chk("b999_ovf", 64'(ovf_b), 64'd1);
      @(negedge clk);

      // reset in cycle 8 of a run
      init_a = 1'b1; bcd_a = 20'h54321;
      @(negedge clk); init_a = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", 64'(busy_a), 64'd0);
      chk("mid_rst_bin",  64'(bin_a),  64'd0);
      chk("mid_rst_done", 64'(done_a), 64'd0);
      run_a(20'h00500, cyc);
      chk("post_rst_lat", 64'(cyc), 64'd18);
      chk("post_rst_bin", 64'(bin_a), 64'd500);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
